// File: rtl/csr_pkg.sv
// ============================================================================
// csr_pkg : machine-mode CSR addresses, mstatus bit positions, trap FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MIE    = 3;
  localparam int MPIE   = 7;
  localparam int MPP_LO = 11;
  localparam int MPP_HI = 12;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_MEPC    = 3'd1,
    S_W_MCAUSE  = 3'd2,
    S_W_MTVAL   = 3'd3,
    S_W_MSTATUS = 3'd4,
    S_T_REDIR   = 3'd5,
    S_M_MSTATUS = 3'd6,
    S_M_REDIR   = 3'd7
  } trap_state_e;

endpackage

`default_nettype wire

// File: rtl/trap_vec_calc.sv
// ============================================================================
// trap_vec_calc : trap target PC from mtvec and mcause (direct / vectored)
// Rev 1.0
// ============================================================================
`default_nettype none

module trap_vec_calc #(
  parameter bit VECTORED = 1'b1
) (
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_cause,
  output logic [31:0] o_target
);

  logic [31:0] w_base;
  logic [31:0] w_off;
  logic        w_vectored;

  assign w_base = {i_mtvec[31:2], 2'b00};
  // Shifting out cause[31:30] leaves exactly {cause[29:0],2'b00}.
  assign w_off  = i_cause << 2;
  // Only mode 01 vectors, and only for interrupts; 1x modes fall back to direct.
  assign w_vectored = VECTORED && (i_mtvec[1:0] == 2'b01) && i_cause[31];
  assign o_target   = w_vectored ? (w_base + w_off) : w_base;

endmodule

`default_nettype wire

// File: rtl/csr_trap_ctrl.sv
// ============================================================================
// csr_trap_ctrl : trap / mret sequencer driving the M-mode CSR file write port
// Rev 1.0
// ============================================================================
`default_nettype none

module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter bit HAS_MTVAL = 1'b1,
  parameter bit VECTORED  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        mret_req,
  output logic        req_ack,
  output logic        busy,
  output logic [11:0] csr_rd_addr,
  input  logic [31:0] csr_rd_data,
  input  logic [31:0] trap_vec,
  input  logic [31:0] exception_pc,
  output logic        csr_wb,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  trap_state_e r_state;
  trap_state_e w_next;
  logic [31:0] r_cause;
  logic [31:0] r_pc;
  logic [31:0] r_tval;
  logic [31:0] w_vec_pc;

  trap_vec_calc #(
    .VECTORED (VECTORED)
  ) u_vec (
    .i_mtvec  (trap_vec),
    .i_cause  (r_cause),
    .o_target (w_vec_pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cause <= '0;
      r_pc    <= '0;
      r_tval  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && trap_req) begin
        r_cause <= trap_cause;
        r_pc    <= trap_pc;
        r_tval  <= trap_val;
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign csr_rd_addr = CSR_MSTATUS;

  always_comb begin
    w_next         = r_state;
    req_ack        = 1'b0;
    csr_wb         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (r_state)
      S_IDLE: begin
        // Gated by reset so no acknowledge leaks out while held in reset.
        if (trap_req) begin
          req_ack = reset;
          w_next  = S_W_MEPC;
        end else if (mret_req) begin
          req_ack = reset;
          w_next  = S_M_MSTATUS;
        end
      end
      S_W_MEPC: begin
        csr_wb    = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = {r_pc[31:2], 2'b00};
        w_next    = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        csr_wb    = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = r_cause;
        w_next    = HAS_MTVAL ? S_W_MTVAL : S_W_MSTATUS;
      end
      S_W_MTVAL: begin
        csr_wb    = 1'b1;
        csr_waddr = CSR_MTVAL;
        csr_wdata = r_tval;
        w_next    = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        csr_wb                    = 1'b1;
        csr_waddr                 = CSR_MSTATUS;
        csr_wdata                 = csr_rd_data;
        csr_wdata[MPIE]           = csr_rd_data[MIE];
        csr_wdata[MIE]            = 1'b0;
        csr_wdata[MPP_HI:MPP_LO]  = 2'b11;
        w_next                    = S_T_REDIR;
      end
      S_T_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = w_vec_pc;
        w_next         = S_IDLE;
      end
      S_M_MSTATUS: begin
        csr_wb                    = 1'b1;
        csr_waddr                 = CSR_MSTATUS;
        csr_wdata                 = csr_rd_data;
        csr_wdata[MIE]            = csr_rd_data[MPIE];
        csr_wdata[MPIE]           = 1'b1;
        csr_wdata[MPP_HI:MPP_LO]  = 2'b11;
        w_next                    = S_M_REDIR;
      end
      S_M_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = exception_pc;
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_csr_trap_ctrl.sv
// ============================================================================
// tb_csr_trap_ctrl : directed-vector bench for csr_trap_ctrl (with/without mtval)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_csr_trap_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: HAS_MTVAL=1
  logic        trap_req0 = 0, mret_req0 = 0;
  logic [31:0] trap_cause0 = 0, trap_pc0 = 0, trap_val0 = 0;
  logic [31:0] csr_rd_data0 = 0, trap_vec0 = 0, exception_pc0 = 0;
  logic        req_ack0, busy0, csr_wb0, redirect_valid0;
  logic [11:0] csr_rd_addr0, csr_waddr0;
  logic [31:0] csr_wdata0, redirect_pc0;

  // Instance 1: HAS_MTVAL=0
  logic        trap_req1 = 0, mret_req1 = 0;
  logic [31:0] trap_cause1 = 0, trap_pc1 = 0, trap_val1 = 0;
  logic [31:0] csr_rd_data1 = 0, trap_vec1 = 0, exception_pc1 = 0;
  logic        req_ack1, busy1, csr_wb1, redirect_valid1;
  logic [11:0] csr_rd_addr1, csr_waddr1;
  logic [31:0] csr_wdata1, redirect_pc1;

  csr_trap_ctrl #(.HAS_MTVAL(1'b1), .VECTORED(1'b1)) dut0 (
    .clk(clk), .reset(reset),
    .trap_req(trap_req0), .trap_cause(trap_cause0), .trap_pc(trap_pc0),
    .trap_val(trap_val0), .mret_req(mret_req0), .req_ack(req_ack0),
    .busy(busy0), .csr_rd_addr(csr_rd_addr0), .csr_rd_data(csr_rd_data0),
    .trap_vec(trap_vec0), .exception_pc(exception_pc0), .csr_wb(csr_wb0),
    .csr_waddr(csr_waddr0), .csr_wdata(csr_wdata0),
    .redirect_valid(redirect_valid0), .redirect_pc(redirect_pc0)
  );

  csr_trap_ctrl #(.HAS_MTVAL(1'b0), .VECTORED(1'b1)) dut1 (
    .clk(clk), .reset(reset),
    .trap_req(trap_req1), .trap_cause(trap_cause1), .trap_pc(trap_pc1),
    .trap_val(trap_val1), .mret_req(mret_req1), .req_ack(req_ack1),
    .busy(busy1), .csr_rd_addr(csr_rd_addr1), .csr_rd_data(csr_rd_data1),
    .trap_vec(trap_vec1), .exception_pc(exception_pc1), .csr_wb(csr_wb1),
    .csr_waddr(csr_waddr1), .csr_wdata(csr_wdata1),
    .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1)
  );

  // Observed outputs packed as {ack, busy, wb, waddr, wdata, redirect_valid, redirect_pc}
  wire [79:0] obs0 = {req_ack0, busy0, csr_wb0, csr_waddr0, csr_wdata0, redirect_valid0, redirect_pc0};
  wire [79:0] obs1 = {req_ack1, busy1, csr_wb1, csr_waddr1, csr_wdata1, redirect_valid1, redirect_pc1};

  int checks = 0;
  int errors = 0;

  // Write log of instance 0, standing in for the CSR file's view of committed writes
  int          wr_cnt0 = 0;
  logic [31:0] mepc0   = '0;
  always @(posedge clk) begin
    if (csr_wb0) begin
      wr_cnt0 <= wr_cnt0 + 1;
      if (csr_waddr0 == 12'h341) mepc0 <= csr_wdata0;
    end
  end

  function automatic logic [79:0] mk(input logic ack, input logic bsy, input logic wb,
                                     input logic [11:0] wa, input logic [31:0] wd,
                                     input logic rv, input logic [31:0] rpc);
    return {ack, bsy, wb, wa, wd, rv, rpc};
  endfunction

  task automatic test_reset();
    trap_req0 = 1'b1;
    mret_req1 = 1'b1;
    #2;
    checks++;
    if (obs0 !== 80'd0) begin errors++; $display("FAIL reset_outs0: got %h expected %h", obs0, 80'd0); end
    checks++;
    if (obs1 !== 80'd0) begin errors++; $display("FAIL reset_outs1: got %h expected %h", obs1, 80'd0); end
    checks++;
    if (csr_rd_addr0 !== 12'h300) begin errors++; $display("FAIL reset_rdaddr0: got %h expected 300", csr_rd_addr0); end
    @(negedge clk);
    checks++;
    if (obs0 !== 80'd0) begin errors++; $display("FAIL reset_held0: got %h expected %h", obs0, 80'd0); end
    trap_req0 = 1'b0;
    mret_req1 = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (obs0 !== 80'd0) begin errors++; $display("FAIL reset_idle0: got %h expected %h", obs0, 80'd0); end
    checks++;
    if (csr_rd_addr1 !== 12'h300) begin errors++; $display("FAIL reset_rdaddr1: got %h expected 300", csr_rd_addr1); end
    @(negedge clk);
  endtask

  task automatic test_trap_direct();
    logic [79:0] tbl [7];
    tbl = '{mk(1,0,0,12'h000,32'h0,0,32'h0),
            mk(0,1,1,12'h341,32'h0000_0080,0,32'h0),
            mk(0,1,1,12'h342,32'h0000_0002,0,32'h0),
            mk(0,1,1,12'h343,32'hDEAD_BEEF,0,32'h0),
            mk(0,1,1,12'h300,32'h0000_1880,0,32'h0),
            mk(0,1,0,12'h000,32'h0,1,32'h0000_0100),
            mk(0,0,0,12'h000,32'h0,0,32'h0)};
    @(negedge clk);
    trap_vec0 = 32'h100; csr_rd_data0 = 32'h8;
    trap_cause0 = 32'd2; trap_pc0 = 32'h80; trap_val0 = 32'hDEAD_BEEF;
    trap_req0 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++;
      if (obs0 !== tbl[i]) begin errors++; $display("FAIL trap_direct row %0d: got %h expected %h", i, obs0, tbl[i]); end
      @(negedge clk);
      if (i == 0) trap_req0 = 1'b0;
    end
  endtask

  task automatic test_mret();
    logic [79:0] tbl [4];
    tbl = '{mk(1,0,0,12'h000,32'h0,0,32'h0),
            mk(0,1,1,12'h300,32'h0000_1888,0,32'h0),
            mk(0,1,0,12'h000,32'h0,1,32'h0000_0080),
            mk(0,0,0,12'h000,32'h0,0,32'h0)};
    @(negedge clk);
    csr_rd_data0 = 32'h1880; exception_pc0 = 32'h80;
    mret_req0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs0 !== tbl[i]) begin errors++; $display("FAIL mret row %0d: got %h expected %h", i, obs0, tbl[i]); end
      @(negedge clk);
      if (i == 0) mret_req0 = 1'b0;
    end
  endtask

  task automatic test_vectored();
    logic [79:0] tbl [2][7];
    logic [31:0] cause [2];
    logic [31:0] pc [2];
    logic [31:0] tval [2];
    cause = '{32'h8000_0007, 32'h0000_0005};
    pc    = '{32'h0000_1003, 32'h0000_2000};
    tval  = '{32'h0000_0000, 32'h0000_1234};
    tbl[0] = '{mk(1,0,0,12'h000,32'h0,0,32'h0),
               mk(0,1,1,12'h341,32'h0000_1000,0,32'h0),
               mk(0,1,1,12'h342,32'h8000_0007,0,32'h0),
               mk(0,1,1,12'h343,32'h0000_0000,0,32'h0),
               mk(0,1,1,12'h300,32'h0000_1880,0,32'h0),
               mk(0,1,0,12'h000,32'h0,1,32'h0000_011C),
               mk(0,0,0,12'h000,32'h0,0,32'h0)};
    tbl[1] = '{mk(1,0,0,12'h000,32'h0,0,32'h0),
               mk(0,1,1,12'h341,32'h0000_2000,0,32'h0),
               mk(0,1,1,12'h342,32'h0000_0005,0,32'h0),
               mk(0,1,1,12'h343,32'h0000_1234,0,32'h0),
               mk(0,1,1,12'h300,32'h0000_1880,0,32'h0),
               mk(0,1,0,12'h000,32'h0,1,32'h0000_0100),
               mk(0,0,0,12'h000,32'h0,0,32'h0)};
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      trap_vec0 = 32'h101; csr_rd_data0 = 32'h8;
      trap_cause0 = cause[v]; trap_pc0 = pc[v]; trap_val0 = tval[v];
      trap_req0 = 1'b1;
      for (int i = 0; i < 7; i++) begin
        #1;
        checks++;
        if (obs0 !== tbl[v][i]) begin errors++; $display("FAIL vectored%0d row %0d: got %h expected %h", v, i, obs0, tbl[v][i]); end
        @(negedge clk);
        if (i == 0) trap_req0 = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [79:0] tbl [10];
    tbl = '{mk(1,0,0,12'h000,32'h0,0,32'h0),
            mk(0,1,1,12'h341,32'h0000_0044,0,32'h0),
            mk(0,1,1,12'h342,32'h0000_0003,0,32'h0),
            mk(0,1,1,12'h343,32'h0000_0055,0,32'h0),
            mk(0,1,1,12'h300,32'h0000_1880,0,32'h0),
            mk(0,1,0,12'h000,32'h0,1,32'h0000_0100),
            mk(1,0,0,12'h000,32'h0,0,32'h0),
            mk(0,1,1,12'h300,32'h0000_1880,0,32'h0),
            mk(0,1,0,12'h000,32'h0,1,32'h0000_0200),
            mk(0,0,0,12'h000,32'h0,0,32'h0)};
    @(negedge clk);
    trap_vec0 = 32'h100; csr_rd_data0 = 32'h8; exception_pc0 = 32'h200;
    trap_cause0 = 32'd3; trap_pc0 = 32'h44; trap_val0 = 32'h55;
    trap_req0 = 1'b1; mret_req0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (obs0 !== tbl[i]) begin errors++; $display("FAIL back_to_back row %0d: got %h expected %h", i, obs0, tbl[i]); end
      @(negedge clk);
      if (i == 0) trap_req0 = 1'b0;
      if (i == 6) mret_req0 = 1'b0;
    end
  endtask

  task automatic test_busy_ignore();
    logic [79:0] tbl [10];
    tbl = '{mk(1,0,0,12'h000,32'h0,0,32'h0),
            mk(0,1,1,12'h300,32'h0000_1880,0,32'h0),
            mk(0,1,0,12'h000,32'h0,1,32'h0000_0300),
            mk(1,0,0,12'h000,32'h0,0,32'h0),
            mk(0,1,1,12'h341,32'h0000_0010,0,32'h0),
            mk(0,1,1,12'h342,32'h8000_0004,0,32'h0),
            mk(0,1,1,12'h343,32'h0000_0000,0,32'h0),
            mk(0,1,1,12'h300,32'h0000_1800,0,32'h0),
            mk(0,1,0,12'h000,32'h0,1,32'h0000_0100),
            mk(0,0,0,12'h000,32'h0,0,32'h0)};
    @(negedge clk);
    trap_vec0 = 32'h103; csr_rd_data0 = 32'h0; exception_pc0 = 32'h300;
    trap_cause0 = 32'h8000_0004; trap_pc0 = 32'h10; trap_val0 = 32'h0;
    mret_req0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (obs0 !== tbl[i]) begin errors++; $display("FAIL busy_ignore row %0d: got %h expected %h", i, obs0, tbl[i]); end
      @(negedge clk);
      if (i == 0) begin mret_req0 = 1'b0; trap_req0 = 1'b1; end
      if (i == 3) trap_req0 = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [79:0] tbl [3];
    int          cnt_start;
    tbl = '{mk(1,0,0,12'h000,32'h0,0,32'h0),
            mk(0,1,1,12'h341,32'h0000_0080,0,32'h0),
            mk(0,1,1,12'h342,32'h0000_0002,0,32'h0)};
    @(negedge clk);
    cnt_start = wr_cnt0;
    trap_vec0 = 32'h100; csr_rd_data0 = 32'h8;
    trap_cause0 = 32'd2; trap_pc0 = 32'h80; trap_val0 = 32'h77;
    trap_req0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs0 !== tbl[i]) begin errors++; $display("FAIL reset_mid row %0d: got %h expected %h", i, obs0, tbl[i]); end
      if (i < 2) @(negedge clk);
      if (i == 0) trap_req0 = 1'b0;
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs0 !== 80'd0) begin errors++; $display("FAIL reset_mid_async: got %h expected %h", obs0, 80'd0); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (obs0 !== 80'd0) begin errors++; $display("FAIL reset_mid_idle row %0d: got %h expected %h", i, obs0, 80'd0); end
      @(negedge clk);
    end
    checks++;
    if (wr_cnt0 - cnt_start !== 1) begin errors++; $display("FAIL reset_mid_writes: got %0d expected 1", wr_cnt0 - cnt_start); end
    checks++;
    if (mepc0 !== 32'h80) begin errors++; $display("FAIL reset_mid_mepc: got %h expected 00000080", mepc0); end
  endtask

  task automatic test_no_mtval();
    logic [79:0] tbl [6];
    tbl = '{mk(1,0,0,12'h000,32'h0,0,32'h0),
            mk(0,1,1,12'h341,32'h0000_0084,0,32'h0),
            mk(0,1,1,12'h342,32'h0000_000B,0,32'h0),
            mk(0,1,1,12'h300,32'h0000_1880,0,32'h0),
            mk(0,1,0,12'h000,32'h0,1,32'h0000_0100),
            mk(0,0,0,12'h000,32'h0,0,32'h0)};
    @(negedge clk);
    trap_vec1 = 32'h100; csr_rd_data1 = 32'h8;
    trap_cause1 = 32'd11; trap_pc1 = 32'h84; trap_val1 = 32'h99;
    trap_req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (obs1 !== tbl[i]) begin errors++; $display("FAIL no_mtval row %0d: got %h expected %h", i, obs1, tbl[i]); end
      @(negedge clk);
      if (i == 0) trap_req1 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_trap_direct();
    test_mret();
    test_vectored();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_no_mtval();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
